// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host sequencer.
package wb_host_pkg;

    localparam int WB_SEL_W    = 4;
    localparam int ADDR_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/wb_host_timer.sv
// Clearable up-counter with a terminal-count flag, used as the per-beat ack watchdog.
module wb_host_timer #(
    parameter int           W      = 8,
    parameter logic [W-1:0] TC_VAL = '1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // tc marks the last cycle that may still see an ack before the host gives up.
    assign tc = (count == TC_VAL);

endmodule

// File: rtl/wb_host_seq.sv
// Wishbone classic host: runs a command of single read/write beats at incrementing
// word addresses, writing a counting pattern or streaming and summing read data.
module wb_host_seq
    import wb_host_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [AW-1:0]       cmd_adr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    input  logic [DW-1:0]       cmd_wdata,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [AW-1:0]       wbm_adr_o,
    output logic [DW-1:0]       wbm_dat_o,
    input  logic [DW-1:0]       wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic                rd_valid,
    output logic [DW-1:0]       rd_data,
    output logic [DW-1:0]       rd_sum,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  we_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic [AW-1:0]         adr_q;
    logic [DW-1:0]         dat_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      k_q;
    logic                  in_req;
    logic                  accept;
    logic                  beat_ack;
    logic                  last_beat;
    logic                  tmr_tc;
    logic                  abort;

    assign in_req    = (state_q == REQ);
    assign accept    = (state_q == IDLE) && cmd_valid;
    assign beat_ack  = in_req && wbm_ack_i;
    assign last_beat = (k_q + LEN_W'(1)) == len_q;
    // An ack on the terminal-count cycle still completes the beat.
    assign abort     = in_req && !wbm_ack_i && tmr_tc;

    wb_host_timer #(
        .W      (TW),
        .TC_VAL (TC_VAL)
    ) u_timer (
        .clk     (wb_clk_i),
        .reset_n (wb_rstn_i),
        .clear   (!in_req),
        .en      (in_req && !wbm_ack_i),
        .tc      (tmr_tc)
    );

    // NOTE: every register here is sequential state, so it uses non-blocking
    // assignments; blocking ones would make same-edge readers order-dependent.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = (cmd_len == '0) ? DONE : REQ;
            REQ: begin
                if (wbm_ack_i)   state_d = last_beat ? DONE : GAP;
                else if (tmr_tc) state_d = IDLE;
            end
            GAP:     state_d = REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            len_q       <= '0;
            k_q         <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_sum      <= '0;
            timeout_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (accept) begin
                we_q        <= cmd_we;
                sel_q       <= cmd_sel;
                adr_q       <= cmd_adr & ~AW'(3);
                dat_q       <= cmd_we ? cmd_wdata : '0;
                len_q       <= cmd_len;
                k_q         <= '0;
                rd_sum      <= '0;
                timeout_err <= 1'b0;
            end else if (beat_ack) begin
                k_q   <= k_q + LEN_W'(1);
                adr_q <= adr_q + AW'(ADDR_STRIDE);
                if (we_q) begin
                    dat_q <= dat_q + DW'(1);
                end else begin
                    rd_data  <= wbm_dat_i;
                    rd_valid <= 1'b1;
                    rd_sum   <= rd_sum + wbm_dat_i;
                end
            end
            if (abort) timeout_err <= 1'b1;
        end
    end

    // Bus fields are only meaningful while strobing and read as zero otherwise.
    assign wbm_cyc_o = in_req || (state_q == GAP);
    assign wbm_stb_o = in_req;
    assign wbm_we_o  = in_req && we_q;
    assign wbm_sel_o = in_req ? sel_q : '0;
    assign wbm_adr_o = in_req ? adr_q : '0;
    assign wbm_dat_o = in_req ? dat_q : '0;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
